// File: rtl/tensor_core_register_streamer.sv
// tensor_core_register_streamer
// Purpose: takes a one-cycle snapshot of the tensor core register file's
// parallel read bus. It then streams that snapshot out as one signed 8-bit
// element per beat over a valid/ready handshake. Each beat carries its flat
// register address, so the sequence mirrors the file's single-element write
// port.
//
// Ports:
//   clock_in            sole clock, rising edge
//   reset_in            asynchronous, active-high reset
//   start_in            request snapshot + stream (honoured only while idle)
//   abort_in            terminate an active stream (no done pulse)
//   snapshot_data_in    parallel read bus, [matrix][row][col] signed bytes
//   stream_ready_in     downstream accepts the current beat
//   stream_valid_out    beat present
//   stream_data_out     element value at stream_address_out
//   stream_address_out  flat element address a -> [a/16][(a%16)/4][a%4]
//   stream_last_out     beat is address NUMBER_OF_REGISTERS-1
//   busy_out            streaming (identical to stream_valid_out)
//   done_out            one-cycle pulse after the final beat is accepted
module tensor_core_register_streamer #(
   parameter  int NUMBER_OF_REGISTERS = 32,
   localparam int ADDR_W              = $clog2(NUMBER_OF_REGISTERS),
   localparam int MATRICES            = (NUMBER_OF_REGISTERS - 1) / 16 + 1
) (
   input  logic                     clock_in,
   input  logic                     reset_in,
   input  logic                     start_in,
   input  logic                     abort_in,
   input  logic signed [7:0]        snapshot_data_in [MATRICES][4][4],
   input  logic                     stream_ready_in,
   output logic                     stream_valid_out,
   output logic signed [7:0]        stream_data_out,
   output logic [ADDR_W-1:0]        stream_address_out,
   output logic                     stream_last_out,
   output logic                     busy_out,
   output logic                     done_out
);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   state_t             state_r;
   state_t             state_next_s;
   logic [ADDR_W-1:0]  index_r;
   logic               done_r;
   logic signed [7:0]  snapshot_r [MATRICES][4][4];
   logic signed [7:0]  element_s;
   logic               transfer_s;
   logic               last_s;

   // Handshake decode; depends only on registered state and the ready input.
   always_comb begin
      last_s     = (index_r == ADDR_W'(NUMBER_OF_REGISTERS - 1));
      transfer_s = (state_r == STREAM) && stream_ready_in;
   end

   // State register.
   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic: a transfer takes priority over abort, so a beat
   // accepted in the same cycle as abort still completes.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (start_in) begin
               state_next_s = STREAM;
            end else begin
               state_next_s = IDLE;
            end
         end
         STREAM: begin
            if (transfer_s && last_s) begin
               state_next_s = IDLE;
            end else if (abort_in) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = STREAM;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // Snapshot capture, beat index and the done pulse register.
   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         snapshot_r <= '{default: '0};
         index_r    <= '0;
         done_r     <= 1'b0;
      end else begin
         done_r <= transfer_s && last_s;
         if ((state_r == IDLE) && start_in) begin
            snapshot_r <= snapshot_data_in;
            index_r    <= '0;
         end else if (transfer_s && !last_s) begin
            index_r <= index_r + ADDR_W'(1);
         end
      end
   end

   // Element select by flat address. Padding slots of a partial last matrix
   // are excluded, so they can never alias onto a narrow index.
   always_comb begin
      element_s = 8'sd0;
      for (int m = 0; m < MATRICES; m++) begin
         for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
               if (((m * 16 + r * 4 + c) < NUMBER_OF_REGISTERS) &&
                   (32'(index_r) == 32'(m * 16 + r * 4 + c))) begin
                  element_s = snapshot_r[m][r][c];
               end else begin
                  element_s = element_s;
               end
            end
         end
      end
   end

   // Output decode from registered state only; idle outputs are forced to 0.
   always_comb begin
      stream_valid_out = (state_r == STREAM);
      busy_out         = (state_r == STREAM);
      done_out         = done_r;
      if (state_r == STREAM) begin
         stream_data_out    = element_s;
         stream_address_out = index_r;
         stream_last_out    = last_s;
      end else begin
         stream_data_out    = 8'sd0;
         stream_address_out = '0;
         stream_last_out    = 1'b0;
      end
   end

endmodule
